// File: rtl/wb_byte_master.sv
// Wishbone pipelined single-beat bus master controlled by a byte-stream
// command channel. 'W' + 4 address + 4 data bytes issues a write, 'R' + 4
// address bytes issues a read, and every command gets a status response
// ('K', 'E' or '?'). A successful read also returns 4 data bytes, MSB first.
module wb_byte_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_stall_i,
  output logic        busy_o
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;
  localparam logic [7:0] RSP_UNK   = 8'h3F;

  // The counter only has to reach TIMEOUT_CYCLES-1: the abort happens at
  // the end of the cycle in which it holds that value.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS_REQ,
    S_BUS_WAIT,
    S_RESP_STATUS,
    S_RESP_DATA
  } state_t;

  state_t        state;
  logic [1:0]    byte_cnt;
  logic          is_write;
  logic          rd_ok;
  logic [31:0]   rdata;
  logic [TW-1:0] tmo_cnt;

  logic rx_fire;
  logic tx_fire;
  logic tmo_hit;

  assign rx_fire = rx_valid_i & rx_ready_o;
  assign tx_fire = tx_valid_o & tx_ready_i;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Command FSM: collects command bytes, runs the bus cycle, streams response.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would let later statements see
  // half-updated state and break the cycle-exact handshakes.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      is_write   <= 1'b0;
      rd_ok      <= 1'b0;
      rdata      <= '0;
      tmo_cnt    <= '0;
      rx_ready_o <= 1'b1;
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      wbm_sel_o  <= '0;
      busy_o     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            busy_o <= 1'b1;
            if (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) begin
              is_write <= (rx_data_i == CMD_WRITE);
              byte_cnt <= '0;
              state    <= S_ADDR;
            end else begin
              rd_ok      <= 1'b0;
              tx_data_o  <= RSP_UNK;
              tx_valid_o <= 1'b1;
              rx_ready_o <= 1'b0;
              state      <= S_RESP_STATUS;
            end
          end
        end

        S_ADDR: begin
          if (rx_fire) begin
            wbm_adr_o <= {wbm_adr_o[23:0], rx_data_i};
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_write) begin
                state <= S_DATA;
              end else begin
                // Launch the read on the cycle after the last address byte.
                wbm_cyc_o  <= 1'b1;
                wbm_stb_o  <= 1'b1;
                wbm_we_o   <= 1'b0;
                wbm_sel_o  <= 4'hF;
                tmo_cnt    <= '0;
                rx_ready_o <= 1'b0;
                state      <= S_BUS_REQ;
              end
            end
          end
        end

        S_DATA: begin
          if (rx_fire) begin
            wbm_dat_o <= {wbm_dat_o[23:0], rx_data_i};
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wbm_cyc_o  <= 1'b1;
              wbm_stb_o  <= 1'b1;
              wbm_we_o   <= 1'b1;
              wbm_sel_o  <= 4'hF;
              tmo_cnt    <= '0;
              rx_ready_o <= 1'b0;
              state      <= S_BUS_REQ;
            end
          end
        end

        S_BUS_REQ, S_BUS_WAIT: begin
          // Termination priority: err over ack, and either over timeout.
          if (wbm_err_i || wbm_ack_i || tmo_hit) begin
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_sel_o  <= '0;
            tx_valid_o <= 1'b1;
            state      <= S_RESP_STATUS;
            if (!wbm_err_i && wbm_ack_i) begin
              rdata     <= wbm_dat_i;
              rd_ok     <= !is_write;
              tx_data_o <= RSP_OK;
            end else begin
              rd_ok     <= 1'b0;
              tx_data_o <= RSP_ERR;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (state == S_BUS_REQ && !wbm_stall_i) begin
              wbm_stb_o <= 1'b0;
              state     <= S_BUS_WAIT;
            end
          end
        end

        S_RESP_STATUS: begin
          if (tx_fire) begin
            if (rd_ok) begin
              tx_data_o <= rdata[31:24];
              rdata     <= {rdata[23:0], 8'h00};
              byte_cnt  <= '0;
              state     <= S_RESP_DATA;
            end else begin
              tx_valid_o <= 1'b0;
              rx_ready_o <= 1'b1;
              busy_o     <= 1'b0;
              state      <= S_IDLE;
            end
          end
        end

        S_RESP_DATA: begin
          if (tx_fire) begin
            if (byte_cnt == 2'd3) begin
              tx_valid_o <= 1'b0;
              rx_ready_o <= 1'b1;
              busy_o     <= 1'b0;
              state      <= S_IDLE;
            end else begin
              tx_data_o <= rdata[31:24];
              rdata     <= {rdata[23:0], 8'h00};
              byte_cnt  <= byte_cnt + 2'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
